// File: rtl/pxs_score_ctrl.sv
// pxs_score_ctrl: pong score keeping, serve/play/game-over sequencing and score blinking
module pxs_score_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       vs_i,
  input  logic       start,
  input  logic       point_l,
  input  logic       point_r,
  output logic [3:0] score_l_tens,
  output logic [3:0] score_l_units,
  output logic [3:0] score_r_tens,
  output logic [3:0] score_r_units,
  output logic       digits_en,
  output logic       play,
  output logic       serve,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  state_t     state;
  logic       vs_q;
  logic [6:0] cnt;
  logic       tick;
  logic [3:0] nl_t, nl_u, nr_t, nr_u;
  logic       win_l, win_r;

  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] u);
    return (t == 4'd9 && u == 4'd9) ? {t, u} : (u == 4'd9) ? {t + 4'd1, 4'd0} : {t, u + 4'd1};
  endfunction

  assign tick = vs_i & ~vs_q;

  // Next BCD score per player and whether that score wins the game
  always_comb begin
    {nl_t, nl_u} = bcd_inc(score_l_tens, score_l_units);
    {nr_t, nr_u} = bcd_inc(score_r_tens, score_r_units);
    win_l = (8'(nl_t) * 8'd10 + 8'(nl_u)) == 8'(WIN_SCORE);
    win_r = (8'(nr_t) * 8'd10 + 8'(nr_u)) == 8'(WIN_SCORE);
  end

  // Game FSM with frame counting, scoring and registered outputs
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state         <= IDLE;
      vs_q          <= 1'b0;
      cnt           <= 7'd0;
      score_l_tens  <= 4'd0;
      score_l_units <= 4'd0;
      score_r_tens  <= 4'd0;
      score_r_units <= 4'd0;
      digits_en     <= 1'b1;
      play          <= 1'b0;
      serve         <= 1'b0;
      winner        <= 2'b00;
    end else begin
      vs_q  <= vs_i;
      serve <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SERVE;
          cnt   <= 7'd0;
        end
        SERVE: if (tick) begin
          if (cnt == 7'(SERVE_FRAMES - 1)) begin
            state <= PLAY;
            serve <= 1'b1;
            play  <= 1'b1;
            cnt   <= 7'd0;
          end else cnt <= cnt + 7'd1;
        end
        PLAY: if (point_l) begin
          {score_l_tens, score_l_units} <= {nl_t, nl_u};
          play  <= 1'b0;
          cnt   <= 7'd0;
          state <= win_l ? OVER : SERVE;
          if (win_l) winner <= 2'b01;
        end else if (point_r) begin
          {score_r_tens, score_r_units} <= {nr_t, nr_u};
          play  <= 1'b0;
          cnt   <= 7'd0;
          state <= win_r ? OVER : SERVE;
          if (win_r) winner <= 2'b10;
        end
        OVER: if (start) begin
          state         <= SERVE;
          cnt           <= 7'd0;
          score_l_tens  <= 4'd0;
          score_l_units <= 4'd0;
          score_r_tens  <= 4'd0;
          score_r_units <= 4'd0;
          winner        <= 2'b00;
          digits_en     <= 1'b1;
        end else if (tick) begin
          if (cnt == 7'(BLINK_FRAMES - 1)) begin
            digits_en <= ~digits_en;
            cnt       <= 7'd0;
          end else cnt <= cnt + 7'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pxs_score_ctrl.sv
// tb_pxs_score_ctrl: random game stimulus checked every cycle against a score/phase model
module tb_pxs_score_ctrl;
  localparam int SF = 2;
  localparam int BF = 2;

  typedef struct {
    int sl, sr, w, ph, fr;
    bit den, sv, vsq;
  } mdl_t;

  logic px_clk = 0, reset = 1, vs_i = 0, start = 0, point_l = 0, point_r = 0;
  logic [3:0] a_lt, a_lu, a_rt, a_ru, b_lt, b_lu, b_rt, b_ru;
  logic a_den, a_play, a_sv, b_den, b_play, b_sv;
  logic [1:0] a_w, b_w;
  int checks = 0, failures = 0, cyc = 0, vw = 1;
  mdl_t m3, m15;

  always #5 px_clk = ~px_clk;

  pxs_score_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(SF), .BLINK_FRAMES(BF)) u3 (
    .px_clk(px_clk), .reset(reset), .vs_i(vs_i), .start(start), .point_l(point_l), .point_r(point_r),
    .score_l_tens(a_lt), .score_l_units(a_lu), .score_r_tens(a_rt), .score_r_units(a_ru),
    .digits_en(a_den), .play(a_play), .serve(a_sv), .winner(a_w));

  pxs_score_ctrl #(.WIN_SCORE(15), .SERVE_FRAMES(SF), .BLINK_FRAMES(BF)) u15 (
    .px_clk(px_clk), .reset(reset), .vs_i(vs_i), .start(start), .point_l(point_l), .point_r(point_r),
    .score_l_tens(b_lt), .score_l_units(b_lu), .score_r_tens(b_rt), .score_r_units(b_ru),
    .digits_en(b_den), .play(b_play), .serve(b_sv), .winner(b_w));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.sl = 0; m.sr = 0; m.w = 0; m.ph = 0; m.fr = 0; m.den = 1; m.sv = 0; m.vsq = 0;
    return m;
  endfunction

  // phases: 0 idle, 1 serve, 2 play, 3 over
  function automatic mdl_t step(mdl_t m, int win);
    mdl_t n = m;
    bit tk = vs_i && !m.vsq;
    if (reset) return mreset();
    n.vsq = vs_i;
    n.sv = 0;
    if (m.ph == 0 && start) begin
      n.ph = 1; n.fr = 0;
    end else if (m.ph == 1 && tk) begin
      n.fr = m.fr + 1;
      if (n.fr == SF) begin n.ph = 2; n.sv = 1; n.fr = 0; end
    end else if (m.ph == 2 && (point_l || point_r)) begin
      if (point_l) n.sl = (m.sl + 1 > 99) ? 99 : m.sl + 1;
      else n.sr = (m.sr + 1 > 99) ? 99 : m.sr + 1;
      n.fr = 0;
      n.ph = (n.sl == win || n.sr == win) ? 3 : 1;
      if (n.ph == 3) n.w = point_l ? 1 : 2;
    end else if (m.ph == 3 && start) begin
      n = mreset(); n.vsq = vs_i; n.ph = 1;
    end else if (m.ph == 3 && tk) begin
      n.fr = m.fr + 1;
      if (n.fr == BF) begin n.den = !m.den; n.fr = 0; end
    end
    return n;
  endfunction

  task automatic cmp(input string who, input mdl_t m, input logic [3:0] lt, lu, rt, ru,
                     input logic den, pl, sv, input logic [1:0] w);
    check({who, "_l_tens"}, lt, m.sl / 10);
    check({who, "_l_units"}, lu, m.sl % 10);
    check({who, "_r_tens"}, rt, m.sr / 10);
    check({who, "_r_units"}, ru, m.sr % 10);
    check({who, "_digits_en"}, den, m.den);
    check({who, "_play"}, pl, m.ph == 2);
    check({who, "_serve"}, sv, m.sv);
    check({who, "_winner"}, w, m.w);
  endtask

  task automatic cycle();
    if (cyc % 20 == 0) vw = $urandom_range(1, 5);
    vs_i = (cyc % 20) < vw;
    @(posedge px_clk);
    m3 = step(m3, 3);
    m15 = step(m15, 15);
    @(negedge px_clk);
    cyc++;
    cmp("w3", m3, a_lt, a_lu, a_rt, a_ru, a_den, a_play, a_sv, a_w);
    cmp("w15", m15, b_lt, b_lu, b_rt, b_ru, b_den, b_play, b_sv, b_w);
  endtask

  initial begin
    int n;
    m3 = mreset();
    m15 = mreset();
    @(negedge px_clk);
    reset = 1;
    repeat (2) cycle();
    reset = 0;
    point_l = 1;
    cycle();
    point_l = 0;
    repeat (3) cycle();
    start = 1;
    cycle();
    start = 0;
    n = 0;
    while (!(m3.ph == 1 && m3.fr == 1) && n < 200) begin
      cycle();
      n++;
    end
    check("serve_tick_wait", int'(n < 200), 1);
    reset = 1;
    cycle();
    reset = 0;
    repeat (5) cycle();
    for (int i = 0; i < 20000; i++) begin
      reset   = ($urandom_range(0, 4999) == 0);
      start   = ($urandom_range(0, 149) == 0);
      point_l = ($urandom_range(0, 19) == 0);
      point_r = ($urandom_range(0, 19) == 0);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
